// File: rtl/config_commit_pkg.sv
// config_commit_pkg: shared width, timeout and state encoding for the config commit path
package config_commit_pkg;
  parameter int CFG_W = 35;
  parameter int TMO_CYC = 15;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STAGED = 2'b01,
    APPLY  = 2'b10
  } state_t;
endpackage

// File: rtl/config_commit_if.sv
// config_commit_if: control-unit/datapath signals of the config commit block
interface config_commit_if #(parameter int CFG_W = config_commit_pkg::CFG_W);
  logic             write_en;
  logic [CFG_W-1:0] configin;
  logic             apply_ack;
  logic             clr_err;
  logic [CFG_W-1:0] active_cfg;
  logic             apply_req;
  logic [CFG_W-1:0] staged_cfg;
  logic             busy;
  logic [3:0]       version;
  logic             drop_err;
  logic             tmo_err;
  logic [1:0]       dbg_state;
  modport master (
    output write_en, configin, apply_ack, clr_err,
    input  active_cfg, apply_req, staged_cfg, busy, version, drop_err, tmo_err, dbg_state
  );
  modport slave (
    input  write_en, configin, apply_ack, clr_err,
    output active_cfg, apply_req, staged_cfg, busy, version, drop_err, tmo_err, dbg_state
  );
endinterface

// File: rtl/cfg_timeout_cnt.sv
// cfg_timeout_cnt: 4-bit apply timeout counter with clear, enable and terminal count
module cfg_timeout_cnt #(
  parameter int TMO = config_commit_pkg::TMO_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [3:0] r_cnt;
  // count waiting cycles; cleared while the word sits in STAGED
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 4'd1;
  assign o_tc = i_en && (r_cnt == 4'(TMO - 1));
endmodule

// File: rtl/config_commit.sv
// config_commit: stages a config word, offers it downstream and commits it on ack
module config_commit #(
  parameter int CFG_W = config_commit_pkg::CFG_W,
  parameter int TMO_CYC = config_commit_pkg::TMO_CYC
) (
  input logic clk,
  input logic arst,
  config_commit_if.slave bus
);
  import config_commit_pkg::*;
  state_t           r_state;
  logic [CFG_W-1:0] r_shadow, r_pend, r_active;
  logic             r_pend_v, r_req, r_drop, r_tmo;
  logic [3:0]       r_ver;
  logic w_apply, w_ack, w_tc, w_leave, w_drain, w_wr_pend, w_free, w_drop, w_tmo;
  assign w_apply   = r_state == APPLY;
  assign w_ack     = w_apply && bus.apply_ack;
  assign w_leave   = w_ack || w_tc;
  assign w_tmo     = w_tc && !bus.apply_ack;
  assign w_drain   = r_pend_v && (r_state == IDLE || w_leave);
  assign w_wr_pend = bus.write_en && (r_state != IDLE || r_pend_v);
  assign w_free    = !r_pend_v || w_drain;
  assign w_drop    = w_wr_pend && !w_free;
  cfg_timeout_cnt #(.TMO(TMO_CYC)) u_tmo (
    .clk  (clk),
    .rst  (arst),
    .i_clr(r_state == STAGED),
    .i_en (w_apply && !bus.apply_ack),
    .o_tc (w_tc)
  );
  // state machine, shadow/pending/active registers and sticky errors
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_active <= '0;
      r_req    <= 1'b0;
      r_ver    <= '0;
      r_drop   <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (r_pend_v || bus.write_en) begin
            r_shadow <= r_pend_v ? r_pend : bus.configin;
            r_state  <= STAGED;
          end
        STAGED: begin
          r_state <= (r_shadow == r_active) ? IDLE : APPLY;
          r_req   <= r_shadow != r_active;
        end
        default:
          if (w_leave) begin
            if (w_ack) begin
              r_active <= r_shadow;
              r_ver    <= r_ver + 4'd1;
            end
            if (r_pend_v) r_shadow <= r_pend;
            r_state <= r_pend_v ? STAGED : IDLE;
            r_req   <= 1'b0;
          end
      endcase
      if (w_wr_pend && w_free) begin
        r_pend   <= bus.configin;
        r_pend_v <= 1'b1;
      end else if (w_drain) r_pend_v <= 1'b0;
      r_drop <= w_drop || (r_drop && !bus.clr_err);
      r_tmo  <= w_tmo || (r_tmo && !bus.clr_err);
    end
  assign bus.active_cfg = r_active;
  assign bus.apply_req  = r_req;
  assign bus.staged_cfg = r_shadow;
  assign bus.busy       = (r_state != IDLE) || r_pend_v;
  assign bus.version    = r_ver;
  assign bus.drop_err   = r_drop;
  assign bus.tmo_err    = r_tmo;
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_config_commit.sv
// tb_config_commit: directed self-checking bench for config_commit
module tb_config_commit;
  logic clk = 1'b0;
  logic arst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  config_commit_if #(.CFG_W(35)) bus ();
  config_commit #(.CFG_W(35), .TMO_CYC(15)) dut (.clk(clk), .arst(arst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [34:0] v);
    bus.write_en = 1'b1;
    bus.configin = v;
    tick();
    bus.write_en = 1'b0;
  endtask
  task automatic ack();
    bus.apply_ack = 1'b1;
    tick();
    bus.apply_ack = 1'b0;
  endtask
  task automatic st(input string tag, input logic [1:0] s, input logic req, input logic [34:0] act, input logic [3:0] ver);
    chk({tag, ".state"}, 64'(bus.dbg_state), 64'(s));
    chk({tag, ".req"}, 64'(bus.apply_req), 64'(req));
    chk({tag, ".active"}, 64'(bus.active_cfg), 64'(act));
    chk({tag, ".ver"}, 64'(bus.version), 64'(ver));
  endtask
  initial begin
    bus.write_en = 1'b0;
    bus.configin = '0;
    bus.apply_ack = 1'b0;
    bus.clr_err = 1'b0;
    #12;
    st("rst", 2'b00, 1'b0, 35'h0, 4'd0);
    chk("rst.staged", 64'(bus.staged_cfg), 64'h0);
    chk("rst.busy", 64'(bus.busy), 64'h0);
    chk("rst.errs", 64'({bus.drop_err, bus.tmo_err}), 64'h0);
    arst = 1'b0;
    tick();
    // basic apply, ack on 2nd APPLY cycle
    wr(35'h1);
    st("s1.stg", 2'b01, 1'b0, 35'h0, 4'd0);
    chk("s1.staged", 64'(bus.staged_cfg), 64'h1);
    chk("s1.busy", 64'(bus.busy), 64'h1);
    tick();
    st("s1.ap1", 2'b10, 1'b1, 35'h0, 4'd0);
    tick();
    st("s1.ap2", 2'b10, 1'b1, 35'h0, 4'd0);
    ack();
    st("s1.done", 2'b00, 1'b0, 35'h1, 4'd1);
    chk("s1.busy", 64'(bus.busy), 64'h0);
    // same word again: no request
    wr(35'h1);
    st("s2.stg", 2'b01, 1'b0, 35'h1, 4'd1);
    tick();
    st("s2.idle", 2'b00, 1'b0, 35'h1, 4'd1);
    // timeout
    wr(35'h3000);
    tick();
    for (int i = 0; i < 14; i++) tick();
    st("s3.wait", 2'b10, 1'b1, 35'h1, 4'd1);
    chk("s3.tmo0", 64'(bus.tmo_err), 64'h0);
    tick();
    st("s3.tmo", 2'b00, 1'b0, 35'h1, 4'd1);
    chk("s3.tmo1", 64'(bus.tmo_err), 64'h1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("s3.clr", 64'(bus.tmo_err), 64'h0);
    // pending first-wins, second write dropped
    wr(35'h2);
    tick();
    wr(35'h7);
    chk("s4.drop0", 64'(bus.drop_err), 64'h0);
    wr(35'h5);
    chk("s4.drop1", 64'(bus.drop_err), 64'h1);
    st("s4.ap", 2'b10, 1'b1, 35'h1, 4'd1);
    ack();
    st("s4.ack1", 2'b01, 1'b0, 35'h2, 4'd2);
    chk("s4.staged", 64'(bus.staged_cfg), 64'h7);
    tick();
    ack();
    st("s4.ack2", 2'b00, 1'b0, 35'h7, 4'd3);
    chk("s4.busy", 64'(bus.busy), 64'h0);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("s4.clr", 64'(bus.drop_err), 64'h0);
    // write on the drain edge is accepted
    wr(35'h8);
    wr(35'h9);
    st("s5.ap", 2'b10, 1'b1, 35'h7, 4'd3);
    bus.write_en = 1'b1;
    bus.configin = 35'hA;
    ack();
    bus.write_en = 1'b0;
    st("s5.drn", 2'b01, 1'b0, 35'h8, 4'd4);
    chk("s5.staged", 64'(bus.staged_cfg), 64'h9);
    chk("s5.drop", 64'(bus.drop_err), 64'h0);
    tick();
    ack();
    st("s5.a2", 2'b01, 1'b0, 35'h9, 4'd5);
    chk("s5.staged2", 64'(bus.staged_cfg), 64'hA);
    tick();
    ack();
    st("s5.a3", 2'b00, 1'b0, 35'hA, 4'd6);
    // async reset mid-APPLY
    wr(35'hB);
    tick();
    st("s6.ap", 2'b10, 1'b1, 35'hA, 4'd6);
    #2 arst = 1'b1;
    #1;
    st("s6.rst", 2'b00, 1'b0, 35'h0, 4'd0);
    chk("s6.staged", 64'(bus.staged_cfg), 64'h0);
    chk("s6.busy", 64'(bus.busy), 64'h0);
    arst = 1'b0;
    tick();
    wr(35'h400000000);
    tick();
    st("s6.ap2", 2'b10, 1'b1, 35'h0, 4'd0);
    ack();
    st("s6.done", 2'b00, 1'b0, 35'h400000000, 4'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/config_commit.md
CONFIG_COMMIT -- requirements
Module: config_commit

Interface
REQ-001 Parameter CFG_W, default 35, width of the configuration word.
REQ-002 Parameter TMO_CYC, default 15, maximum cycles apply_req waits for apply_ack.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 arst  input  1  asynchronous, active-high reset.
REQ-005 write_en  input  1  one-cycle strobe from the upstream control unit; configin valid while high.
REQ-006 configin  input  CFG_W  configuration word driven by the control unit's configout.
REQ-007 apply_ack  input  1  downstream datapath acknowledges the offered word.
REQ-008 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-009 active_cfg  output  CFG_W  currently applied configuration.
REQ-010 apply_req  output  1  registered; high while the staged word is offered downstream.
REQ-011 staged_cfg  output  CFG_W  word being offered; stable while apply_req is high.
REQ-012 busy  output  1  high in any state other than IDLE, or while pending is valid.
REQ-013 version  output  4  count of successful applies; wraps 15 -> 0.
REQ-014 drop_err  output  1  sticky; a write was discarded.
REQ-015 tmo_err  output  1  sticky; an apply timed out.
REQ-016 dbg_state  output  2  encoding IDLE=00, STAGED=01, APPLY=10.

Function
REQ-017 In IDLE, write_en=1 shall capture configin into the shadow register and enter STAGED the next cycle.
REQ-018 STAGED shall last exactly one cycle: shadow == active_cfg -> IDLE with no request and no version change; otherwise -> APPLY.
REQ-019 apply_req shall be 1 exactly when state is APPLY; the first request cycle is two clocks after the accepted write_en.
REQ-020 In APPLY, apply_ack=1 shall load active_cfg from the shadow, increment version modulo 16, and leave APPLY on the same edge.
REQ-021 apply_ack shall be ignored outside APPLY.
REQ-022 A timeout counter shall clear on entry to APPLY and increment each APPLY cycle without ack; after TMO_CYC cycles without ack, tmo_err shall set, active_cfg and version shall remain unchanged, and APPLY shall be left.
REQ-023 On leaving APPLY (ack or timeout): pending valid -> move pending into the shadow, clear pending, enter STAGED; otherwise enter IDLE.
REQ-024 A write_en in STAGED or APPLY shall go to a one-deep pending register if it is empty; otherwise the word shall be discarded and drop_err set.
REQ-025 A write_en on the same edge that pending is drained into the shadow shall be accepted into pending (no drop).
REQ-026 A later write shall never overwrite an occupied pending register (first-wins).
REQ-027 clr_err=1 shall clear drop_err and tmo_err unless a new error occurs in the same cycle; the new error wins.
REQ-028 All outputs shall come from registers; there shall be no combinational path from inputs to outputs.

Reset
REQ-029 arst shall immediately force: state IDLE, active_cfg 0, staged_cfg 0, pending invalid, apply_req 0, version 0, drop_err 0, tmo_err 0, timeout counter 0.
REQ-030 arst asserted during APPLY shall abandon the request with no apply; after release, the block shall accept a new write.

Structure
REQ-031 A shared package shall hold CFG_W, TMO_CYC, and the state encoding constants (IDLE, STAGED, APPLY), common with the control unit.
REQ-032 The 4-bit timeout counter with clear/enable/terminal-count shall be one sub-module, cfg_timeout_cnt; all other logic shall be in config_commit.

Verification
REQ-033 Scenario: reset, then write 35'h1 with ack on the 2nd APPLY cycle -> apply_req high for 2 cycles, active_cfg=35'h1, version=1.
REQ-034 Scenario: rewrite 35'h1 when active_cfg=35'h1 -> STAGED then IDLE, apply_req stays 0, version unchanged.
REQ-035 Scenario: write 35'h3000 with ack held 0 -> after 15 APPLY cycles, tmo_err=1, active_cfg unchanged, state IDLE; clr_err=1 -> tmo_err=0.
REQ-036 Scenario: in APPLY write 35'h7, then 35'h5 -> 35'h7 held pending, 35'h5 dropped with drop_err=1; after ack, 35'h7 is staged and applied, version +2 total.
REQ-037 Scenario: write_en on the same cycle as ack with pending full -> pending drains to the shadow, the new word is accepted into pending, drop_err stays 0.
REQ-038 Scenario: arst pulse mid-APPLY -> all outputs reset immediately; a following write of 35'h400000000 applies normally with version=1.
